// File: rtl/page_leaf_bft_driver.sv
// rtl/page_leaf_bft_driver.sv - BFT-side leaf driver for one page slot: downlink/uplink FIFOs and reset/start sequencing.
// Optional packet/drop counters are enabled with PAGE_DRV_PKT_CNT_EN.
module page_leaf_bft_driver #(
  parameter int PKT_W      = 49,
  parameter int FIFO_DEPTH = 8,
  parameter int RST_HOLD   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PKT_W-1:0] tree_in_data,
  input  logic             tree_in_valid,
  output logic             tree_in_ready,
  output logic [PKT_W-1:0] tree_out_data,
  output logic             tree_out_valid,
  input  logic             tree_out_ready,
  output logic [PKT_W-1:0] page_din,
  input  logic [PKT_W-1:0] page_dout,
  output logic             page_resend,
  output logic             page_reset,
  output logic             page_ap_start,
  input  logic             ap_start_in
`ifdef PAGE_DRV_PKT_CNT_EN
  ,
  output logic [31:0]      dn_pkt_cnt,
  output logic [31:0]      up_pkt_cnt,
  output logic [15:0]      drop_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = $clog2(RST_HOLD + 1);

  typedef enum logic {HOLD, RUN} state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;

  logic [PKT_W-1:0] dn_mem [FIFO_DEPTH];
  logic [AW-1:0]    dn_wr, dn_rd;
  logic [CW-1:0]    dn_cnt, dn_cnt_d;
  logic             dn_push, dn_pop;

  logic [PKT_W-1:0] up_mem [FIFO_DEPTH];
  logic [AW-1:0]    up_wr, up_rd, up_rd_d;
  logic [CW-1:0]    up_cnt, up_cnt_d;
  logic             up_in, up_full, up_push, up_pop, up_drop;
  logic [PKT_W-1:0] up_head_d;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      HOLD: begin
        if (hold_cnt_q == HW'(RST_HOLD)) state_d = RUN;
        else hold_cnt_d = hold_cnt_q + HW'(1);
      end
      RUN: state_d = RUN;
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HOLD;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Downlink: the page never stalls, so in RUN the FIFO drains one entry per cycle.
  always_comb begin
    dn_push  = tree_in_valid & tree_in_ready;
    dn_pop   = (state_q == RUN) & (dn_cnt != '0);
    dn_cnt_d = dn_cnt + CW'(dn_push) - CW'(dn_pop);
  end

  // Uplink: a pop at full occupancy frees the slot for a same-cycle push.
  always_comb begin
    up_in    = page_dout[PKT_W-1];
    up_pop   = tree_out_valid & tree_out_ready;
    up_full  = (up_cnt == CW'(FIFO_DEPTH));
    up_push  = up_in & (~up_full | up_pop);
    up_drop  = up_in & up_full & ~up_pop;
    up_cnt_d = up_cnt + CW'(up_push) - CW'(up_pop);
    up_rd_d  = up_rd + AW'(up_pop);
    if ((up_cnt - CW'(up_pop)) == '0) up_head_d = page_dout;
    else up_head_d = up_mem[up_rd_d];
  end

  always_ff @(posedge clk) begin
    if (dn_push) dn_mem[dn_wr] <= tree_in_data;
    if (up_push) up_mem[up_wr] <= page_dout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dn_wr          <= '0;
      dn_rd          <= '0;
      dn_cnt         <= '0;
      up_wr          <= '0;
      up_rd          <= '0;
      up_cnt         <= '0;
      page_din       <= '0;
      page_resend    <= 1'b0;
      page_reset     <= 1'b1;
      page_ap_start  <= 1'b0;
      tree_in_ready  <= 1'b0;
      tree_out_valid <= 1'b0;
      tree_out_data  <= '0;
    end else begin
      if (dn_push) dn_wr <= dn_wr + AW'(1);
      if (dn_pop) dn_rd <= dn_rd + AW'(1);
      dn_cnt <= dn_cnt_d;
      page_din <= dn_pop ? {1'b1, dn_mem[dn_rd][PKT_W-2:0]} : '0;

      if (up_push) up_wr <= up_wr + AW'(1);
      up_rd  <= up_rd_d;
      up_cnt <= up_cnt_d;
      tree_out_valid <= (up_cnt_d != '0);
      if (up_cnt_d != '0) tree_out_data <= up_head_d;
      page_resend <= up_drop;

      page_reset    <= (state_d == HOLD);
      page_ap_start <= (state_d == RUN) & ap_start_in;
      tree_in_ready <= (state_d == RUN) & (dn_cnt_d < CW'(FIFO_DEPTH));
    end
  end

`ifdef PAGE_DRV_PKT_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      dn_pkt_cnt <= '0;
      up_pkt_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      dn_pkt_cnt <= dn_pkt_cnt + 32'(dn_pop);
      up_pkt_cnt <= up_pkt_cnt + 32'(up_push);
      if (up_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_page_leaf_bft_driver.sv
// tb/tb_page_leaf_bft_driver.sv - directed self-checking bench for page_leaf_bft_driver.
module tb_page_leaf_bft_driver;

  localparam int PKT_W = 49;

  logic             clk = 1'b0;
  logic             reset;
  logic [PKT_W-1:0] tree_in_data;
  logic             tree_in_valid;
  logic             tree_in_ready;
  logic [PKT_W-1:0] tree_out_data;
  logic             tree_out_valid;
  logic             tree_out_ready;
  logic [PKT_W-1:0] page_din;
  logic [PKT_W-1:0] page_dout;
  logic             page_resend;
  logic             page_reset;
  logic             page_ap_start;
  logic             ap_start_in;
`ifdef PAGE_DRV_PKT_CNT_EN
  logic [31:0]      dn_pkt_cnt;
  logic [31:0]      up_pkt_cnt;
  logic [15:0]      drop_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  page_leaf_bft_driver dut (
    .clk            (clk),
    .reset          (reset),
    .tree_in_data   (tree_in_data),
    .tree_in_valid  (tree_in_valid),
    .tree_in_ready  (tree_in_ready),
    .tree_out_data  (tree_out_data),
    .tree_out_valid (tree_out_valid),
    .tree_out_ready (tree_out_ready),
    .page_din       (page_din),
    .page_dout      (page_dout),
    .page_resend    (page_resend),
    .page_reset     (page_reset),
    .page_ap_start  (page_ap_start),
    .ap_start_in    (ap_start_in)
`ifdef PAGE_DRV_PKT_CNT_EN
    ,
    .dn_pkt_cnt     (dn_pkt_cnt),
    .up_pkt_cnt     (up_pkt_cnt),
    .drop_cnt       (drop_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PKT_W-1:0] pkt(input logic v, input int p);
    return {v, 48'(p)};
  endfunction

  initial begin
    int idx;
    int nout;
    logic acc;

    reset = 1'b1;
    tree_in_data = '0;
    tree_in_valid = 1'b0;
    tree_out_ready = 1'b0;
    page_dout = '0;
    ap_start_in = 1'b0;
    step();
    step();

    check("rst_page_reset", 64'(page_reset), 64'd1);
    check("rst_page_din", 64'(page_din), 64'd0);
    check("rst_in_ready", 64'(tree_in_ready), 64'd0);
    check("rst_out_valid", 64'(tree_out_valid), 64'd0);
    check("rst_resend", 64'(page_resend), 64'd0);
    check("rst_ap_start", 64'(page_ap_start), 64'd0);

    // Four HOLD cycles after reset falls, then RUN.
    reset = 1'b0;
    ap_start_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("hold_page_reset", 64'(page_reset), 64'd1);
      check("hold_in_ready", 64'(tree_in_ready), 64'd0);
      check("hold_ap_start", 64'(page_ap_start), 64'd0);
    end
    step();
    check("run_page_reset", 64'(page_reset), 64'd0);
    check("run_in_ready", 64'(tree_in_ready), 64'd1);
    check("run_ap_start", 64'(page_ap_start), 64'd1);
    ap_start_in = 1'b0;
    step();
    check("ap_start_off", 64'(page_ap_start), 64'd0);

    // Single downlink packet with valid flag clear: appears with bit 48 set two cycles later.
    tree_in_data = pkt(1'b0, 32'h1234);
    tree_in_valid = 1'b1;
    step();
    tree_in_valid = 1'b0;
    tree_in_data = '0;
    check("dn_single_t1", 64'(page_din), 64'd0);
    step();
    check("dn_single_t2", 64'(page_din), 64'h1_0000_0000_1234);
    step();
    check("dn_single_t3", 64'(page_din), 64'd0);

    // Back-to-back downlink stream in RUN.
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        tree_in_data = pkt(1'b0, 32'h100 + i);
        tree_in_valid = 1'b1;
      end else begin
        tree_in_valid = 1'b0;
      end
      step();
      check("dn_stream_ready", 64'(tree_in_ready), 64'd1);
      if (i == 0 || i == 9) check("dn_stream_idle", 64'(page_din), 64'd0);
      else check("dn_stream_data", 64'(page_din), 64'(pkt(1'b1, 32'h100 + i - 1)));
    end

    // Valid held across the HOLD window: nothing accepted until RUN, then 8 emerge in order.
    reset = 1'b1;
    step();
    reset = 1'b0;
    idx = 0;
    nout = 0;
    tree_in_valid = 1'b1;
    tree_in_data = pkt(1'b0, 32'h200);
    for (int c = 0; c < 16; c++) begin
      acc = tree_in_valid & tree_in_ready;
      step();
      if (acc) begin
        idx++;
        tree_in_data = pkt(1'b0, 32'h200 + idx);
        if (idx == 8) tree_in_valid = 1'b0;
      end
      if (c < 4) check("fill_hold_ready", 64'(tree_in_ready), 64'd0);
      if (page_din[PKT_W-1]) begin
        check("fill_data", 64'(page_din), 64'(pkt(1'b1, 32'h200 + nout)));
        nout++;
      end
    end
    check("fill_accepted", 64'(idx), 64'd8);
    check("fill_emerged", 64'(nout), 64'd8);

    // Uplink backpressure: 8 stored, 9th dropped with a resend pulse.
    for (int i = 0; i < 9; i++) begin
      page_dout = pkt(1'b1, 32'h300 + i);
      step();
      check("up_head", 64'(tree_out_data), 64'(pkt(1'b1, 32'h300)));
      check("up_valid", 64'(tree_out_valid), 64'd1);
      check("up_resend", 64'(page_resend), (i == 8) ? 64'd1 : 64'd0);
    end
    page_dout = '0;
    step();
    check("up_resend_end", 64'(page_resend), 64'd0);

    // Push and pop together at full: no drop.
    page_dout = pkt(1'b1, 32'h308);
    tree_out_ready = 1'b1;
    step();
    page_dout = '0;
    tree_out_ready = 1'b0;
    check("up_pp_resend", 64'(page_resend), 64'd0);
    check("up_pp_head", 64'(tree_out_data), 64'(pkt(1'b1, 32'h301)));
    tree_out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check("up_drain_valid", 64'(tree_out_valid), 64'd1);
      check("up_drain_data", 64'(tree_out_data), 64'(pkt(1'b1, 32'h301 + j)));
      step();
    end
    check("up_drain_empty", 64'(tree_out_valid), 64'd0);
    tree_out_ready = 1'b0;

    // Consecutive drops give consecutive resend pulses.
    for (int i = 0; i < 8; i++) begin
      page_dout = pkt(1'b1, 32'h400 + i);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      page_dout = pkt(1'b1, 32'h4FF);
      step();
      check("up_drop_resend", 64'(page_resend), 64'd1);
    end
    page_dout = '0;
    step();
    check("up_drop_resend_end", 64'(page_resend), 64'd0);
    check("up_drop_head", 64'(tree_out_data), 64'(pkt(1'b1, 32'h400)));

    // Reset mid-stream with data in both directions.
    tree_in_data = pkt(1'b0, 32'h555);
    tree_in_valid = 1'b1;
    step();
    tree_in_valid = 1'b0;
    reset = 1'b1;
    step();
    check("mid_page_din", 64'(page_din), 64'd0);
    check("mid_out_valid", 64'(tree_out_valid), 64'd0);
    check("mid_page_reset", 64'(page_reset), 64'd1);
    check("mid_in_ready", 64'(tree_in_ready), 64'd0);
    check("mid_resend", 64'(page_resend), 64'd0);
`ifdef PAGE_DRV_PKT_CNT_EN
    check("mid_dn_cnt", 64'(dn_pkt_cnt), 64'd0);
    check("mid_up_cnt", 64'(up_pkt_cnt), 64'd0);
    check("mid_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
    reset = 1'b0;
    tree_out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("post_out_valid", 64'(tree_out_valid), 64'd0);
      check("post_page_din", 64'(page_din), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
